// File: rtl/pipe_issue_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_issue_ctrl
//
// Issue controller in front of the 4-stage register/ALU/memory pipeline.
// Incoming instructions are queued in a small FIFO. The head instruction is
// checked against the destination registers still in flight. Dependent
// instructions wait (bubbles) until their producer has been written back.
// Illegal func codes are dropped with a one-cycle error pulse. Hazard stall
// cycles are counted in a saturating counter.
//
// Ports
//   clk          : single clock, rising edge
//   rst_n        : asynchronous active-low reset
//   in_valid     : upstream instruction present on in_instr
//   in_instr     : {rs1[23:20], rs2[19:16], rd[15:12], func[11:8], addr[7:0]}
//   in_ready     : FIFO can accept (registered, 0 while in reset)
//   flush        : synchronous clear of queued, unissued instructions
//   rs1/rs2/rd   : register fields of the issued instruction
//   func         : ALU function of the issued instruction
//   addr         : memory address of the issued instruction
//   issue_valid  : one-cycle strobe, the fields above are valid
//   err_illegal  : one-cycle pulse when the head is dropped as illegal
//   stall_cnt    : saturating count of hazard stall cycles
//   busy         : FIFO non-empty or any in-flight destination tracked
// ---------------------------------------------------------------------------
module pipe_issue_ctrl #(
  parameter int DEPTH    = 4,
  parameter int HZ_DEPTH = 2,
  parameter int MAX_FUNC = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [23:0] in_instr,
  output logic        in_ready,
  input  logic        flush,
  output logic [3:0]  rs1,
  output logic [3:0]  rs2,
  output logic [3:0]  rd,
  output logic [3:0]  func,
  output logic [7:0]  addr,
  output logic        issue_valid,
  output logic        err_illegal,
  output logic [15:0] stall_cnt,
  output logic        busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [3:0]    MAX_FUNC_C = 4'(MAX_FUNC);
  localparam logic [15:0]   STALL_MAX  = 16'hFFFF;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;

  // FIFO storage and bookkeeping
  logic [23:0]   mem_q [DEPTH];
  logic [23:0]   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // In-flight destination tracker, index 0 is the most recent issue
  logic [HZ_DEPTH-1:0] hz_v_q, hz_v_d;
  logic [3:0]          hz_rd_q [HZ_DEPTH];
  logic [3:0]          hz_rd_d [HZ_DEPTH];

  logic [1:0] state_q, state_d;

  // Registered outputs
  logic [3:0]  rs1_q, rs1_d;
  logic [3:0]  rs2_q, rs2_d;
  logic [3:0]  rd_q, rd_d;
  logic [3:0]  func_q, func_d;
  logic [7:0]  addr_q, addr_d;
  logic        issue_valid_q, issue_valid_d;
  logic        err_illegal_q, err_illegal_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        busy_q, busy_d;
  logic        in_ready_q, in_ready_d;

  // Head decode and decisions
  logic [23:0] head_s;
  logic [3:0]  head_rs1_s, head_rs2_s, head_rd_s, head_func_s;
  logic [7:0]  head_addr_s;
  logic        empty_s;
  logic        illegal_s;
  logic        hazard_s;
  logic        push_s;
  logic        drop_s;
  logic        stall_s;
  logic        issue_s;
  logic        pop_s;

  // Head field extraction and empty flag
  always_comb begin
    head_s      = mem_q[rd_ptr_q];
    head_rs1_s  = head_s[23:20];
    head_rs2_s  = head_s[19:16];
    head_rd_s   = head_s[15:12];
    head_func_s = head_s[11:8];
    head_addr_s = head_s[7:0];
    empty_s     = (count_q == CNT_ZERO);
    illegal_s   = (head_func_s > MAX_FUNC_C);
  end

  // RAW hazard: a head source matches any destination still in flight.
  // The head's own rd is never compared, so rd == rs is not a hazard.
  always_comb begin
    hazard_s = 1'b0;
    for (int i = 0; i < HZ_DEPTH; i++) begin
      if (hz_v_q[i] && ((hz_rd_q[i] == head_rs1_s) || (hz_rd_q[i] == head_rs2_s))) begin
        hazard_s = 1'b1;
      end else begin
        hazard_s = hazard_s;
      end
    end
  end

  // Per-edge action for the head. The head is evaluated in every state, so
  // an instruction pushed while IDLE can issue on the very next edge. Flush
  // suppresses every action on its edge. Illegal beats hazard.
  always_comb begin
    push_s  = in_valid && in_ready_q && !flush;
    drop_s  = !empty_s && !flush && illegal_s;
    stall_s = !empty_s && !flush && !illegal_s && hazard_s;
    issue_s = !empty_s && !flush && !illegal_s && !hazard_s;
    pop_s   = drop_s || issue_s;
  end

  // FIFO next-state: write on push, advance read on pop, clear on flush.
  // in_ready is taken from the registered full flag, so a push while full
  // is refused even when the head pops on the same edge.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      // Drop everything queued; the write pointer stays, the read pointer
      // catches up so the FIFO reads as empty.
      rd_ptr_d = wr_ptr_q;
      count_d  = CNT_ZERO;
    end else begin
      if (push_s) begin
        mem_d[wr_ptr_q] = in_instr;
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Hazard tracker shift: always shifts, even during flush, so instructions
  // already in the pipeline are still tracked until written back.
  always_comb begin
    hz_v_d     = hz_v_q;
    hz_rd_d    = hz_rd_q;
    hz_v_d[0]  = issue_s;
    hz_rd_d[0] = head_rd_s;
    for (int i = 1; i < HZ_DEPTH; i++) begin
      hz_v_d[i]  = hz_v_q[i-1];
      hz_rd_d[i] = hz_rd_q[i-1];
    end
  end

  // FSM: tracks whether the controller is idle, running or stalled
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_RUN, ST_STALL: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (stall_s) begin
          state_d = ST_STALL;
        end else if (count_d == CNT_ZERO) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output register next values; fields hold when nothing issues
  always_comb begin
    rs1_d  = rs1_q;
    rs2_d  = rs2_q;
    rd_d   = rd_q;
    func_d = func_q;
    addr_d = addr_q;
    if (issue_s) begin
      rs1_d  = head_rs1_s;
      rs2_d  = head_rs2_s;
      rd_d   = head_rd_s;
      func_d = head_func_s;
      addr_d = head_addr_s;
    end else begin
      rs1_d  = rs1_q;
      rs2_d  = rs2_q;
      rd_d   = rd_q;
      func_d = func_q;
      addr_d = addr_q;
    end
    issue_valid_d = issue_s;
    err_illegal_d = drop_s;
    if (stall_s && (stall_cnt_q != STALL_MAX)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    busy_d     = (count_d != CNT_ZERO) || (|hz_v_d);
    in_ready_d = (count_d != FULL_CNT);
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q         <= '{default: 24'd0};
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= CNT_ZERO;
      hz_v_q        <= '0;
      hz_rd_q       <= '{default: 4'd0};
      state_q       <= ST_IDLE;
      rs1_q         <= 4'd0;
      rs2_q         <= 4'd0;
      rd_q          <= 4'd0;
      func_q        <= 4'd0;
      addr_q        <= 8'd0;
      issue_valid_q <= 1'b0;
      err_illegal_q <= 1'b0;
      stall_cnt_q   <= 16'd0;
      busy_q        <= 1'b0;
      in_ready_q    <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      hz_v_q        <= hz_v_d;
      hz_rd_q       <= hz_rd_d;
      state_q       <= state_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      rd_q          <= rd_d;
      func_q        <= func_d;
      addr_q        <= addr_d;
      issue_valid_q <= issue_valid_d;
      err_illegal_q <= err_illegal_d;
      stall_cnt_q   <= stall_cnt_d;
      busy_q        <= busy_d;
      in_ready_q    <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign rs1         = rs1_q;
  assign rs2         = rs2_q;
  assign rd          = rd_q;
  assign func        = func_q;
  assign addr        = addr_q;
  assign issue_valid = issue_valid_q;
  assign err_illegal = err_illegal_q;
  assign stall_cnt   = stall_cnt_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_issue_ctrl
//
// Directed bench for pipe_issue_ctrl. Accepted legal instructions are pushed
// onto an expected queue when driven; a monitor pops and compares on every
// issue strobe. Cycle-exact timing points are checked inline.
// ---------------------------------------------------------------------------
module tb_pipe_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [23:0] in_instr;
  logic        in_ready;
  logic        flush;
  logic [3:0]  rs1, rs2, rd, func;
  logic [7:0]  addr;
  logic        issue_valid;
  logic        err_illegal;
  logic [15:0] stall_cnt;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int n_issue = 0;
  int n_err_seen = 0;
  logic [23:0] exp_q[$];

  always #5 clk = ~clk;

  pipe_issue_ctrl #(.DEPTH(4), .HZ_DEPTH(2), .MAX_FUNC(11)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_instr    (in_instr),
    .in_ready    (in_ready),
    .flush       (flush),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd          (rd),
    .func        (func),
    .addr        (addr),
    .issue_valid (issue_valid),
    .err_illegal (err_illegal),
    .stall_cnt   (stall_cnt),
    .busy        (busy)
  );

  function automatic logic [23:0] mk(input logic [3:0] s1, input logic [3:0] s2,
                                     input logic [3:0] d, input logic [3:0] fn,
                                     input logic [7:0] a);
    return {s1, s2, d, fn, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: one sample per clock, after the edge has settled
  always @(posedge clk) begin
    #1;
    if (issue_valid === 1'b1) begin
      n_issue++;
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL issue_unexpected observed=%0h expected=none", {rs1, rs2, rd, func, addr});
      end
      if (exp_q.size() > 0) begin
        chk("issue_fields", {8'd0, rs1, rs2, rd, func, addr}, {8'd0, exp_q.pop_front()});
      end
    end
    if (err_illegal === 1'b1) n_err_seen++;
  end

  // One clock: drive inputs now, return 2 time units after the next edge
  task automatic cyc(input logic v, input logic [23:0] ins, input logic fl);
    if (fl) exp_q.delete();
    else if (v && in_ready && (ins[11:8] <= 4'd11)) exp_q.push_back(ins);
    in_valid = v;
    in_instr = ins;
    flush    = fl;
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    cyc(1'b0, 24'd0, 1'b0);
  endtask

  task automatic drain(input string tag, input int bound);
    for (int i = 0; i < bound && busy; i++) idle();
    chk(tag, {31'd0, busy}, 32'd0);
    chk({tag, "_sb_empty"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    logic [23:0] a_i, b_i, c_i, x_i, l1_i, l2_i, d_i;
    logic [23:0] p_i [7];
    int base_issue;

    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] a_i, b_i, c_i, x_i, l1_i, l2_i, d_i;
    logic [23:0] p_i [7];
    int base_issue;

    a_i  = mk(4'd3, 4'd5, 4'd10, 4'd0, 8'd125);
    b_i  = mk(4'd3, 4'd8, 4'd12, 4'd2, 8'd126);
    c_i  = mk(4'd10, 4'd5, 4'd14, 4'd1, 8'd128);
    d_i  = mk(4'd1, 4'd2, 4'd3, 4'd4, 8'd200);
    l1_i = mk(4'd6, 4'd7, 4'd8, 4'd3, 8'd10);
    x_i  = mk(4'd8, 4'd7, 4'd9, 4'd12, 8'd11);
    l2_i = mk(4'd6, 4'd7, 4'd11, 4'd11, 8'd12);
    p_i[0] = mk(4'd0, 4'd0, 4'd1, 4'd5, 8'd40);
    p_i[1] = mk(4'd1, 4'd0, 4'd2, 4'd6, 8'd41);
    p_i[2] = mk(4'd2, 4'd0, 4'd3, 4'd7, 8'd42);
    p_i[3] = mk(4'd3, 4'd0, 4'd4, 4'd8, 8'd43);
    p_i[4] = mk(4'd4, 4'd0, 4'd5, 4'd9, 8'd44);
    p_i[5] = mk(4'd5, 4'd0, 4'd6, 4'd10, 8'd45);
    p_i[6] = mk(4'd0, 4'd0, 4'd7, 4'd1, 8'd46);

    // Reset state
    rst_n = 1'b0; in_valid = 1'b0; in_instr = 24'd0; flush = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_issue_valid", {31'd0, issue_valid}, 32'd0);
    chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_fields", {8'd0, rs1, rs2, rd, func, addr}, 32'd0);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #2;
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // 1. Independent stream: back-to-back issue
    cyc(1'b1, a_i, 1'b0);
    chk("t1_iv_e0", {31'd0, issue_valid}, 32'd0);
    chk("t1_busy_e0", {31'd0, busy}, 32'd1);
    cyc(1'b1, b_i, 1'b0);
    chk("t1_iv_a", {31'd0, issue_valid}, 32'd1);
    idle();
    chk("t1_iv_b", {31'd0, issue_valid}, 32'd1);
    chk("t1_rd_b", {28'd0, rd}, 32'd12);
    idle();
    chk("t1_iv_off", {31'd0, issue_valid}, 32'd0);
    chk("t1_hold_addr", {24'd0, addr}, 32'd126);
    chk("t1_stall", {16'd0, stall_cnt}, 32'd0);
    drain("t1_drain", 20);

    // 2. RAW hazard: two bubbles, then busy falls two cycles after issue
    cyc(1'b1, a_i, 1'b0);
    cyc(1'b1, c_i, 1'b0);
    chk("t2_iv_a", {31'd0, issue_valid}, 32'd1);
    idle();
    chk("t2_bubble1", {31'd0, issue_valid}, 32'd0);
    chk("t2_stall1", {16'd0, stall_cnt}, 32'd1);
    idle();
    chk("t2_bubble2", {31'd0, issue_valid}, 32'd0);
    chk("t2_stall2", {16'd0, stall_cnt}, 32'd2);
    idle();
    chk("t2_iv_c", {31'd0, issue_valid}, 32'd1);
    chk("t2_rs1_c", {28'd0, rs1}, 32'd10);
    idle();
    chk("t2_busy_c1", {31'd0, busy}, 32'd1);
    idle();
    chk("t2_busy_c2", {31'd0, busy}, 32'd0);
    chk("t2_stall_final", {16'd0, stall_cnt}, 32'd2);

    // 3. Full FIFO via a dependent chain; 5th queued push refused
    base_issue = n_issue;
    for (int i = 0; i < 6; i++) cyc(1'b1, p_i[i], 1'b0);
    chk("t3_full_ready", {31'd0, in_ready}, 32'd0);
    cyc(1'b1, p_i[6], 1'b0);
    chk("t3_still_full", {31'd0, in_ready}, 32'd0);
    drain("t3_drain", 40);
    chk("t3_issue_count", n_issue - base_issue, 32'd6);
    chk("t3_stall", {16'd0, stall_cnt}, 32'd12);

    // 4. Illegal func between two legal ones (also a would-be hazard)
    base_issue = n_issue;
    cyc(1'b1, l1_i, 1'b0);
    cyc(1'b1, x_i, 1'b0);
    cyc(1'b1, l2_i, 1'b0);
    chk("t4_err_pulse", {31'd0, err_illegal}, 32'd1);
    chk("t4_no_issue", {31'd0, issue_valid}, 32'd0);
    idle();
    chk("t4_err_clear", {31'd0, err_illegal}, 32'd0);
    chk("t4_iv_l2", {31'd0, issue_valid}, 32'd1);
    chk("t4_func_l2", {28'd0, func}, 32'd11);
    drain("t4_drain", 20);
    chk("t4_err_count", n_err_seen, 32'd1);
    chk("t4_issue_count", n_issue - base_issue, 32'd2);
    chk("t4_stall", {16'd0, stall_cnt}, 32'd12);

    // 5. Flush while the dependent waits; a same-cycle push is discarded
    base_issue = n_issue;
    cyc(1'b1, a_i, 1'b0);
    cyc(1'b1, c_i, 1'b0);
    cyc(1'b1, d_i, 1'b1);
    chk("t5_no_issue", {31'd0, issue_valid}, 32'd0);
    chk("t5_busy_inflight", {31'd0, busy}, 32'd1);
    chk("t5_ready", {31'd0, in_ready}, 32'd1);
    idle();
    chk("t5_busy_drained", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 5; i++) idle();
    chk("t5_issue_count", n_issue - base_issue, 32'd1);

    // 6. Reset while stalled
    base_issue = n_issue;
    cyc(1'b1, a_i, 1'b0);
    cyc(1'b1, c_i, 1'b0);
    idle();
    chk("t6_stalled_iv", {31'd0, issue_valid}, 32'd0);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_rst_iv", {31'd0, issue_valid}, 32'd0);
    chk("t6_rst_stall", {16'd0, stall_cnt}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_ready", {31'd0, in_ready}, 32'd0);
    chk("t6_rst_fields", {8'd0, rs1, rs2, rd, func, addr}, 32'd0);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #2;
    chk("t6_rel_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 5; i++) idle();
    chk("t6_issue_count", n_issue - base_issue, 32'd1);
    chk("t6_stall_after", {16'd0, stall_cnt}, 32'd0);
    chk("t6_busy_after", {31'd0, busy}, 32'd0);
    chk("t6_fields_after", {8'd0, rs1, rs2, rd, func, addr}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_issue_ctrl.md
Name: pipe_issue_ctrl

Overview:
Single-clock issue controller that sits in front of the 4-stage register/ALU/memory pipeline (16x16 regbank, 256-entry data memory, 4-bit func ALU).
- Buffers incoming instructions in a small FIFO.
- Detects read-after-write hazards against in-flight destination registers and inserts bubbles until the hazard clears.
- Drives the pipeline's rs1/rs2/rd/func/addr inputs with a registered issue strobe.
- Drops illegal func codes and counts stall cycles for performance visibility.

Parameters:
- DEPTH, 4: instruction FIFO entries; must be a power of 2, minimum 2.
- HZ_DEPTH, 2: cycles from issue until the issued rd is written back and readable by a later issue.
- MAX_FUNC, 11: highest legal func code; codes above it are illegal.

Ports:
- clk  in  1: single clock, rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- in_valid  in  1: upstream has an instruction on in_instr.
- in_instr  in  24: {rs1[23:20], rs2[19:16], rd[15:12], func[11:8], addr[7:0]}.
- in_ready  out  1: FIFO can accept; push occurs when in_valid and in_ready are both high.
- flush  in  1: synchronous clear of queued, unissued instructions.
- rs1, rs2, rd, func  out  4 each: fields of the issued instruction, to the pipeline.
- addr  out  8: memory address of the issued instruction.
- issue_valid  out  1: one-cycle strobe; the fields above are valid this cycle.
- err_illegal  out  1: one-cycle pulse when the head instruction is dropped for an illegal func.
- stall_cnt  out  16: count of hazard-stall cycles, saturating.
- busy  out  1: FIFO non-empty or any hazard entry valid.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO pointers, count, hazard entries, all output registers and stall_cnt go to 0; FSM goes to IDLE.
  - in_ready is forced 0 while rst_n is low and is 1 on the first cycle after release.
  - Reset mid-stall discards all queued and in-flight tracking with no issue.
- FIFO:
  - in_ready = !full. A push is refused when full even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full leaves count unchanged.
  - Pointers wrap modulo DEPTH.
  - A pushed instruction becomes the head at the next edge; earliest issue is 1 cycle after push.
- Hazard tracker:
  - HZ_DEPTH entries of {v, rd}, shifted every edge.
  - hz[0] <= {issuing this edge, head rd}; hz[i] <= hz[i-1].
  - hazard = head rs1 or head rs2 equals any valid hz[i].rd.
  - A dependent instruction therefore issues exactly HZ_DEPTH bubbles after its producer. An instruction whose rd matches its own rs1 or rs2 is not a hazard.
- FSM states:
  - IDLE: FIFO empty. Go to RUN when not empty.
  - RUN, head illegal (func > MAX_FUNC): pop; pulse err_illegal; issue_valid=0; hz[0] shifts in v=0.
  - RUN, hazard: issue_valid=0; go to STALL; stall_cnt++.
  - RUN, otherwise: pop; register fields; issue_valid=1. Return to IDLE if the FIFO becomes empty.
  - STALL: stall_cnt++ each cycle the hazard persists. Go to RUN on the cycle the hazard clears; the head issues on that edge.
- Illegal check has priority over the hazard check.
- Output fields hold their last issued values when issue_valid=0.
- flush:
  - Empties the FIFO at the edge; any issue on that edge is suppressed; next state is IDLE.
  - Hazard entries keep shifting (in-flight instructions complete); busy stays high until they drain.
  - A push in the same cycle as flush is discarded.
- stall_cnt saturates at 16'hFFFF and never wraps.

Test Plan:
1. Independent stream: push A(rs1=3, rs2=5, rd=10, func=0, addr=125), then B(rs1=3, rs2=8, rd=12, func=2, addr=126) on consecutive cycles -> issue_valid high 2 consecutive cycles with the A then B fields; stall_cnt=0.
2. RAW hazard: push A(rd=10), then C(rs1=10, rs2=5, rd=14, func=1, addr=128) -> C issues exactly 2 cycles after A (2 bubbles); stall_cnt=2; busy drops 2 cycles after C issues.
3. Full FIFO: hold issue back with a chain of dependents, push until 4 queued -> in_ready=0; a 5th push is not accepted; each entry then issues in order with pointers wrapping correctly.
4. Illegal func: push func=12 between two legal instructions -> single err_illegal pulse; no issue for it; the following instruction issues the next cycle.
5. Flush during stall: queue C behind A's hazard, assert flush for 1 cycle -> C never issues; FIFO empty; busy falls after the hazard entries drain.
6. Reset mid-operation: drop rst_n during STALL -> all outputs 0 immediately; after release in_ready=1, stall_cnt=0, and no stale issue occurs.
